// File: rtl/control_sequencer.sv
// Microcode control unit: counts machine microsteps off the synchronized step clock
// and decodes opcode/flags into the registered control word, with HLT/resume run gating.
module control_sequencer #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LAST_STEP   = 4
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic        step_clock,
    input  logic [3:0]  opcode,
    input  logic        carry_flag,
    input  logic        zero_flag,
    input  logic        resume,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        run
);

    localparam int unsigned CTRL_W = 16;
    localparam int unsigned STEP_W = 3;
    localparam int unsigned OP_W   = 4;

    localparam logic [CTRL_W-1:0] CW_FETCH_ADDR = 16'h4004;
    localparam logic [CTRL_W-1:0] CW_FETCH_INSN = 16'h1408;

    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_edge;
    logic                   r_strobe;
    logic [STEP_W-1:0]      r_step;
    logic [CTRL_W-1:0]      r_ctrl;
    logic                   r_hlt_prev;
    logic                   r_latch;
    logic                   r_run;

    logic                   w_fall;
    logic                   w_advance;
    logic                   w_hlt_rise;
    logic [STEP_W-1:0]      w_step_next;

    // Microcode ROM: fetch steps are shared, execute steps depend on opcode and flags.
    function automatic logic [CTRL_W-1:0] f_decode(
        input logic [STEP_W-1:0] s,
        input logic [OP_W-1:0]   op,
        input logic              c,
        input logic              z
    );
        logic [CTRL_W-1:0] w;
        w = '0;
        case (s)
            3'd0: w = CW_FETCH_ADDR;
            3'd1: w = CW_FETCH_INSN;
            3'd2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: w = 16'h4800;
                    OP_LDI: w = 16'h0A00;
                    OP_JMP: w = 16'h0802;
                    OP_JC:  w = c ? 16'h0802 : 16'h0000;
                    OP_JZ:  w = z ? 16'h0802 : 16'h0000;
                    OP_OUT: w = 16'h0110;
                    OP_HLT: w = 16'h8000;
                    default: w = '0;
                endcase
            end
            3'd3: begin
                case (op)
                    OP_LDA:         w = 16'h1200;
                    OP_ADD, OP_SUB: w = 16'h1020;
                    OP_STA:         w = 16'h2100;
                    default:        w = '0;
                endcase
            end
            3'd4: begin
                case (op)
                    OP_ADD:  w = 16'h0281;
                    OP_SUB:  w = 16'h02C1;
                    default: w = '0;
                endcase
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    assign w_fall      = r_edge & ~r_sync[SYNC_STAGES-1];
    assign w_advance   = r_strobe & ~r_latch;
    assign w_hlt_rise  = r_ctrl[CTRL_W-1] & ~r_hlt_prev;
    assign w_step_next = !w_advance ? r_step :
                         (r_step == STEP_W'(LAST_STEP)) ? '0 : r_step + STEP_W'(1);

    // Step clock is asynchronous: synchronize, then register a one-cycle falling-edge strobe.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync   <= '0;
            r_edge   <= 1'b0;
            r_strobe <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], step_clock};
            r_edge   <= r_sync[SYNC_STAGES-1];
            r_strobe <= w_fall;
        end
    end

    // Step and control word move together; ctrl tracks the step it is about to hold.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_step <= '0;
            r_ctrl <= CW_FETCH_ADDR;
        end else begin
            r_step <= w_step_next;
            r_ctrl <= f_decode(w_step_next, opcode, carry_flag, zero_flag);
        end
    end

    // Only the HLT rising edge sets the latch, so a lingering HLT bit cannot re-halt.
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hlt_prev <= 1'b0;
            r_latch    <= 1'b0;
            r_run      <= 1'b1;
        end else begin
            r_hlt_prev <= r_ctrl[CTRL_W-1];
            if (w_hlt_rise) begin
                r_latch <= 1'b1;
            end else if (resume) begin
                r_latch <= 1'b0;
            end
            r_run <= ~r_latch;
        end
    end

    assign ctrl = r_ctrl;
    assign step = r_step;
    assign run  = r_run;

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Microcode control unit for the 8-bit breadboard-style computer: the consumer end of the auto/manual clock block's step interface. Samples the gated machine clock, keeps its own 5-step microstep counter, and decodes opcode plus flags into the registered 16-bit control word that drives the bus and registers. On HLT it drops `run`, which feeds the clock block's active-high `halt` enable and stops the machine until `resume`.

## Interface
Parameters
- `SYNC_STAGES`, 2: synchronizer depth on `step_clock` (min 2).
- `LAST_STEP`, 4: final microstep index; counter wraps to 0 after it.

Ports
- `system_clock`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `step_clock`  in  1  gated machine clock (`out_clock` of clock block); asynchronous to logic, treated as data.
- `opcode`  in  4  instruction register upper nibble.
- `carry_flag`  in  1  flags register carry.
- `zero_flag`  in  1  flags register zero.
- `resume`  in  1  synchronous pulse; clears halt.
- `ctrl`  out  16  registered control word: [15]HLT [14]MI [13]RI [12]RO [11]IO [10]II [9]AI [8]AO [7]EO [6]SU [5]BI [4]OI [3]CE [2]CO [1]J [0]FI.
- `step`  out  3  current microstep 0..LAST_STEP, for display.
- `run`  out  1  1 = machine may clock; to clock block `halt`.

## Operation
- `step_clock` passes SYNC_STAGES flops, then an edge register; falling edge (prev 1, now 0) = one-cycle `strobe`.
- On `strobe` while not halted: `step` <= (step==LAST_STEP) ? 0 : step+1. Strobes while halted are ignored.
- `ctrl` registered every cycle from decode(next step, opcode, flags); flags sampled combinationally at decode.
- Steps common to all opcodes: T0 CO|MI = 16'h4004; T1 RO|II|CE = 16'h1408.
- T2/T3/T4 by opcode (others 0):
  - 0001 LDA: 16'h4800, 16'h1200.
  - 0010 ADD: 16'h4800, 16'h1020, 16'h0281.
  - 0011 SUB: 16'h4800, 16'h1020, 16'h02C1.
  - 0100 STA: 16'h4800, 16'h2100.
  - 0101 LDI: 16'h0A00.
  - 0110 JMP: 16'h0802.
  - 0111 JC: 16'h0802 if carry_flag else 0; 1000 JZ: same with zero_flag.
  - 1110 OUT: 16'h0110.
  - 1111 HLT: 16'h8000.
  - 0000 and undefined 1001–1101: NOP (all zero at T2–T4).
- Halt latch: set on rising edge of ctrl[15] (registered prev copy); cleared by `resume`. `run` = ~latch, registered.
- `resume` and HLT rising edge same cycle: set wins. `resume` while not halted: no effect.
- HLT bit stays asserted in `ctrl` until the next strobe; no re-latch because only its edge sets.

## Timing
- Reset values: step=0, ctrl=16'h4004, run=1, latch=0, sync/edge flops=0 (so first falling edge needs a prior high).
- Latency `step_clock` fall -> `strobe`: SYNC_STAGES+1 cycles (3 default). `strobe` -> new `step` and `ctrl`: 1 cycle, both update together.
- ctrl[15] rise -> latch: 1 cycle; latch -> `run` low: 1 cycle (2 cycles after ctrl[15]).
- `resume` -> `run` high: 2 cycles.
- Datapath consumes `ctrl` on rising `step_clock`; `step_clock` high/low phases must each exceed SYNC_STAGES+3 system cycles.
- Reset mid-instruction: immediate return to reset values; next strobe goes to step 1.

## Test plan
- Reset, 5 falling edges on step_clock, opcode 0000 -> step 1,2,3,4,0; ctrl 1408,0,0,0,4004; each update exactly 4 cycles after the edge.
- opcode 0011, step through T2–T4 -> ctrl 4800,1020,02C1.
- opcode 0111 with carry_flag=0 then 1 -> T2 ctrl 0000 then 0802; same for 1000/zero_flag.
- opcode 1111 at T2 -> ctrl 8000, run 0 two cycles later; extra edges ignored (step stays 2); resume -> run 1 after 2 cycles, next edges -> step 3,4,0, no re-halt.
- resume coincident with ctrl[15] rise -> run still goes 0.
- reset_n low mid-step 3 of ADD -> step 0, ctrl 4004, run 1 asynchronously.
